// File: rtl/feed_scheduler.sv
// feed_scheduler
//   Watches the running 24h BCD time bus and decides when the pet feeder
//   dispenses. Holds NUM_SLOTS programmable HH:MM feed times plus a manual
//   feed key, runs the motor for DISPENSE_SECONDS second ticks, then locks
//   out further dispensing for COOLDOWN_SECONDS ticks. One trigger arriving
//   while busy is remembered and served when the cooldown ends.
//
// Ports
//   Clk, nReset                       clock, synchronous active-low reset
//   chour2..csecond1                  current time, BCD digits
//   wr_en, wr_slot, wr_hour2..wr_minute1, wr_enable
//                                     slot write port (one-cycle strobe)
//   nFeed                             manual feed key, active low, synchronised
//   motor_on                          dispense motor drive
//   busy                              FSM not idle
//   feed_count                        dispenses since reset, saturating at 255
//   last_slot                         slot behind the latest scheduled dispense
//   last_manual                       latest dispense came from the key
//   wr_err                            one-cycle pulse on a rejected write
module feed_scheduler #(
  parameter int NUM_SLOTS        = 4,
  parameter int DISPENSE_SECONDS = 5,
  parameter int COOLDOWN_SECONDS = 10,
  localparam int SW = $clog2(NUM_SLOTS)
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [3:0]    chour2,
  input  logic [3:0]    chour1,
  input  logic [3:0]    cminute2,
  input  logic [3:0]    cminute1,
  input  logic [3:0]    csecond2,
  input  logic [3:0]    csecond1,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic [3:0]    wr_hour2,
  input  logic [3:0]    wr_hour1,
  input  logic [3:0]    wr_minute2,
  input  logic [3:0]    wr_minute1,
  input  logic          wr_enable,
  input  logic          nFeed,
  output logic          motor_on,
  output logic          busy,
  output logic [7:0]    feed_count,
  output logic [SW-1:0] last_slot,
  output logic          last_manual,
  output logic          wr_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [7:0] DISP_CNT = 8'(DISPENSE_SECONDS);
  localparam logic [7:0] COOL_CNT = 8'(COOLDOWN_SECONDS);

  // Slot storage
  logic [3:0] slot_h2 [NUM_SLOTS];
  logic [3:0] slot_h1 [NUM_SLOTS];
  logic [3:0] slot_m2 [NUM_SLOTS];
  logic [3:0] slot_m1 [NUM_SLOTS];
  logic       slot_en [NUM_SLOTS];

  // Edge detect history
  logic [3:0] prev_sec;
  logic       prev_feed;

  // FSM state and registers
  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic          pending, pending_n;
  logic [SW-1:0] pend_slot, pend_slot_n;
  logic          pend_manual, pend_manual_n;
  logic [7:0]    feed_count_n;
  logic [SW-1:0] last_slot_n;
  logic          last_manual_n;

  // Trigger decode
  logic          tick;
  logic          at_minute;
  logic          match;
  logic [SW-1:0] match_idx;
  logic          manual_edge;
  logic          trigger;
  logic          wr_ok;

  // Dispense start request from the FSM
  logic          start;
  logic [SW-1:0] start_slot;
  logic          start_manual;

  assign tick        = (csecond1 != prev_sec);
  assign at_minute   = tick && (csecond2 == 4'd0) && (csecond1 == 4'd0);
  assign manual_edge = prev_feed && !nFeed;
  assign trigger     = match || manual_edge;

  assign wr_ok = (wr_hour2 <= 4'd2) && (wr_hour1 <= 4'd9) &&
                 (wr_minute2 <= 4'd5) && (wr_minute1 <= 4'd9) &&
                 !((wr_hour2 == 4'd2) && (wr_hour1 > 4'd3)) &&
                 (int'(wr_slot) < NUM_SLOTS);

  assign motor_on = (state == DISPENSE);
  assign busy     = (state != IDLE);

  // Lowest enabled matching slot wins; registered contents give the
  // pre-write view when a write lands in the same cycle.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!match && at_minute && slot_en[i] &&
          slot_h2[i] == chour2 && slot_h1[i] == chour1 &&
          slot_m2[i] == cminute2 && slot_m1[i] == cminute1) begin
        match     = 1'b1;
        match_idx = SW'(i);
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pending_n     = pending;
    pend_slot_n   = pend_slot;
    pend_manual_n = pend_manual;
    start         = 1'b0;
    start_slot    = match_idx;
    start_manual  = !match;

    case (state)
      IDLE: begin
        if (trigger) start = 1'b1;
      end

      DISPENSE: begin
        if (tick) begin
          if (cnt <= 8'd1) begin
            state_n = COOLDOWN;
            cnt_n   = COOL_CNT;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        if (trigger && !pending) begin
          pending_n     = 1'b1;
          pend_slot_n   = match_idx;
          pend_manual_n = !match;
        end
      end

      COOLDOWN: begin
        // cnt==0 on entry covers a zero-length cooldown
        if (cnt == 8'd0 || (tick && cnt == 8'd1)) begin
          if (pending) begin
            start        = 1'b1;
            start_slot   = pend_slot;
            start_manual = pend_manual;
            pending_n    = 1'b0;
          end else if (trigger) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (tick) cnt_n = cnt - 8'd1;
          if (trigger && !pending) begin
            pending_n     = 1'b1;
            pend_slot_n   = match_idx;
            pend_manual_n = !match;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n = DISPENSE;
      cnt_n   = DISP_CNT;
    end
  end

  always_comb begin
    feed_count_n  = feed_count;
    last_slot_n   = last_slot;
    last_manual_n = last_manual;
    if (start) begin
      if (feed_count != 8'hFF) feed_count_n = feed_count + 8'd1;
      if (!start_manual) last_slot_n = start_slot;
      last_manual_n = start_manual;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      pend_slot   <= '0;
      pend_manual <= 1'b0;
      feed_count  <= '0;
      last_slot   <= '0;
      last_manual <= 1'b0;
      prev_sec    <= csecond1;
      prev_feed   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pending     <= pending_n;
      pend_slot   <= pend_slot_n;
      pend_manual <= pend_manual_n;
      feed_count  <= feed_count_n;
      last_slot   <= last_slot_n;
      last_manual <= last_manual_n;
      prev_sec    <= csecond1;
      prev_feed   <= nFeed;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      wr_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_h2[i] <= '0;
        slot_h1[i] <= '0;
        slot_m2[i] <= '0;
        slot_m1[i] <= '0;
        slot_en[i] <= 1'b0;
      end
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_en && wr_ok) begin
        slot_h2[wr_slot] <= wr_hour2;
        slot_h1[wr_slot] <= wr_hour1;
        slot_m2[wr_slot] <= wr_minute2;
        slot_m1[wr_slot] <= wr_minute1;
        slot_en[wr_slot] <= wr_enable;
      end
    end
  end

endmodule

// File: tb/tb_feed_scheduler.sv
// Bench for feed_scheduler: directed time/key/write sequences. Expected
// dispense and write-error events go into a queue; a negedge monitor pops
// and compares on every motor_on rise and every wr_err pulse.
module tb_feed_scheduler;

  localparam int SW = 2;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [3:0]    chour2, chour1, cminute2, cminute1, csecond2, csecond1;
  logic          wr_en;
  logic [SW-1:0] wr_slot;
  logic [3:0]    wr_hour2, wr_hour1, wr_minute2, wr_minute1;
  logic          wr_enable;
  logic          nFeed;
  logic          motor_on;
  logic          busy;
  logic [7:0]    feed_count;
  logic [SW-1:0] last_slot;
  logic          last_manual;
  logic          wr_err;

  always #5 Clk = ~Clk;

  feed_scheduler #(
    .NUM_SLOTS(4),
    .DISPENSE_SECONDS(5),
    .COOLDOWN_SECONDS(10)
  ) dut (
    .Clk(Clk), .nReset(nReset),
    .chour2(chour2), .chour1(chour1), .cminute2(cminute2), .cminute1(cminute1),
    .csecond2(csecond2), .csecond1(csecond1),
    .wr_en(wr_en), .wr_slot(wr_slot),
    .wr_hour2(wr_hour2), .wr_hour1(wr_hour1),
    .wr_minute2(wr_minute2), .wr_minute1(wr_minute1),
    .wr_enable(wr_enable), .nFeed(nFeed),
    .motor_on(motor_on), .busy(busy), .feed_count(feed_count),
    .last_slot(last_slot), .last_manual(last_manual), .wr_err(wr_err)
  );

  typedef struct {
    bit is_err;
    int cnt;
    int slot;
    bit man;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_disp(input int c, input int s, input bit m);
    exp_t e;
    e.is_err = 1'b0; e.cnt = c; e.slot = s; e.man = m;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.cnt = 0; e.slot = 0; e.man = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: compare each observed event against the oldest expectation
  logic prev_motor = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (wr_err === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wr_err actual=1 expected=none");
      end else begin
        e = q.pop_front();
        check("sb_wr_err_kind", 32'(!e.is_err), 32'd0);
      end
    end
    if (motor_on === 1'b1 && prev_motor !== 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_dispense actual=feed_count %0d expected=none", feed_count);
      end else begin
        e = q.pop_front();
        check("sb_disp_kind", 32'(e.is_err), 32'd0);
        check("sb_feed_count", 32'(feed_count), 32'(e.cnt));
        check("sb_last_slot", 32'(last_slot), 32'(e.slot));
        check("sb_last_manual", 32'(last_manual), 32'(e.man));
      end
    end
    prev_motor <= motor_on;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    chour2 = a; chour1 = b; cminute2 = c; cminute1 = d; csecond2 = e; csecond1 = f;
  endtask

  // Advance seconds only (no minute carry); one cycle per tick
  task automatic tick1();
    if (csecond1 == 4'd9) begin
      csecond1 = 4'd0;
      csecond2 = (csecond2 == 4'd5) ? 4'd0 : csecond2 + 4'd1;
    end else begin
      csecond1 = csecond1 + 4'd1;
    end
    cyc(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic wr(input logic [SW-1:0] s, input logic [3:0] a, b, c, d, input logic en);
    wr_slot = s; wr_hour2 = a; wr_hour1 = b; wr_minute2 = c; wr_minute1 = d;
    wr_enable = en; wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; nFeed = 1'b1; wr_en = 1'b0; wr_slot = '0;
    wr_hour2 = '0; wr_hour1 = '0; wr_minute2 = '0; wr_minute1 = '0; wr_enable = 1'b0;
    set_time(0, 0, 0, 0, 0, 0);
    cyc(3);
    check("rst_motor_on", 32'(motor_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_feed_count", 32'(feed_count), 32'd0);
    check("rst_last_slot", 32'(last_slot), 32'd0);
    check("rst_last_manual", 32'(last_manual), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    nReset = 1'b1;
    cyc(3);
    check("no_event_after_reset", 32'(busy), 32'd0);

    // Scheduled dispense at 07:30:00, latency and duration
    wr(0, 0, 7, 3, 0, 1'b1);
    set_time(0, 7, 2, 9, 5, 9); cyc(1);
    set_time(0, 7, 3, 0, 0, 0);
    check("trigger_cycle_motor", 32'(motor_on), 32'd0);
    push_disp(1, 0, 1'b0);
    cyc(1);
    check("latency_motor_on", 32'(motor_on), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick1();
      check("dispense_hold", 32'(motor_on), 32'd1);
    end
    tick1();
    check("dispense_end_motor", 32'(motor_on), 32'd0);
    check("cooldown_busy", 32'(busy), 32'd1);
    ticks(9);
    check("cooldown_hold", 32'(busy), 32'd1);
    tick1();
    check("cooldown_end", 32'(busy), 32'd0);

    // Write validation
    push_err();
    wr(2, 2, 4, 0, 0, 1'b1);
    check("wr_err_pulse", 32'(wr_err), 32'd1);
    cyc(1);
    check("wr_err_one_cycle", 32'(wr_err), 32'd0);
    wr(2, 2, 3, 5, 9, 1'b1);
    cyc(1);
    check("valid_write_no_err", 32'(wr_err), 32'd0);
    push_err();
    wr(2, 2, 3, 6, 0, 1'b1);
    cyc(1);
    set_time(2, 3, 5, 8, 5, 9); cyc(1);
    set_time(2, 3, 5, 9, 0, 0);
    push_disp(2, 2, 1'b0);
    cyc(1);
    check("slot2_motor_on", 32'(motor_on), 32'd1);
    ticks(15);
    check("slot2_idle", 32'(busy), 32'd0);

    // Two slots on 12:00, lowest index wins, single dispense
    wr(1, 1, 2, 0, 0, 1'b1);
    wr(3, 1, 2, 0, 0, 1'b1);
    set_time(1, 1, 5, 9, 5, 9); cyc(1);
    set_time(1, 2, 0, 0, 0, 0);
    push_disp(3, 1, 1'b0);
    cyc(1);
    check("dual_motor_on", 32'(motor_on), 32'd1);
    ticks(15);
    check("dual_idle", 32'(busy), 32'd0);
    check("dual_feed_count", 32'(feed_count), 32'd3);

    // Manual key, two extra edges during dispense -> one pending dispense
    nFeed = 1'b0;
    push_disp(4, 1, 1'b1);
    cyc(1);
    check("manual_latency", 32'(motor_on), 32'd1);
    nFeed = 1'b1; cyc(1);
    tick1();
    nFeed = 1'b0; cyc(1); nFeed = 1'b1; cyc(1);
    tick1();
    nFeed = 1'b0; cyc(1); nFeed = 1'b1; cyc(1);
    ticks(3);
    check("manual_dispense_end", 32'(motor_on), 32'd0);
    push_disp(5, 1, 1'b1);
    ticks(9);
    check("pending_waits_cooldown", 32'(motor_on), 32'd0);
    tick1();
    check("pending_redispense", 32'(motor_on), 32'd1);
    ticks(15);
    check("pending_idle", 32'(busy), 32'd0);
    check("pending_feed_count", 32'(feed_count), 32'd5);

    // Reset mid-dispense
    nFeed = 1'b0;
    push_disp(6, 1, 1'b1);
    cyc(1);
    nFeed = 1'b1;
    ticks(2);
    check("pre_reset_motor", 32'(motor_on), 32'd1);
    nReset = 1'b0;
    cyc(1);
    check("reset_motor_off", 32'(motor_on), 32'd0);
    check("reset_feed_count", 32'(feed_count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_last_slot", 32'(last_slot), 32'd0);
    check("reset_last_manual", 32'(last_manual), 32'd0);
    nReset = 1'b1;
    cyc(5);
    check("post_reset_motor", 32'(motor_on), 32'd0);
    check("post_reset_count", 32'(feed_count), 32'd0);
    set_time(0, 7, 2, 9, 5, 9); cyc(1);
    set_time(0, 7, 3, 0, 0, 0); cyc(2);
    check("slots_cleared", 32'(motor_on), 32'd0);

    // Time reload: one tick only, then time frozen
    wr(0, 0, 9, 0, 0, 1'b1);
    set_time(0, 8, 1, 5, 0, 7); cyc(1);
    check("reload_no_match", 32'(busy), 32'd0);
    set_time(0, 9, 0, 0, 0, 0);
    push_disp(1, 0, 1'b0);
    cyc(1);
    check("reload_motor_on", 32'(motor_on), 32'd1);
    cyc(20);
    check("frozen_motor_on", 32'(motor_on), 32'd1);
    check("frozen_busy", 32'(busy), 32'd1);

    cyc(2);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
